key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder.sv | 159 +++++++++++++++
 tb/tb_key_event_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder: converts a debounced key level into single-cycle press, release, short, long and repeat events.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied low.
module key_event_decoder #(
  parameter int LONG_CNT   = 100_000_000,
  parameter int REPEAT_CNT = 20_000_000,
  parameter int CNT_W      = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam int CNT_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  if (LONG_CNT < 2 || REPEAT_CNT < 2 || (CNT_MAX - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("key_event_decoder: illegal LONG_CNT/REPEAT_CNT/CNT_W combination");
  end

  state_t           state_q, state_d;
  logic             key_q;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             busy_q;
  logic             rise, fall;
  logic             repeat_d;
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CNT - 1);
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             repeat_q;
`endif

  // Next-state and event decode; a release always wins over a same-cycle long or repeat.
  always_comb begin
    rise       = key_in & ~key_q;
    fall       = ~key_in & key_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = PRESSED;
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          state_d   = IDLE;
        end else if (hold_cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
`ifdef KEY_AUTO_REPEAT_EN
          rpt_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          if (rpt_cnt_q == RPT_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_ONE;
          end
`else
          state_d = LONG_HELD;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= 1'b0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_in;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      busy_q     <= (state_d != IDLE);
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  // Repeat interval counter, cleared explicitly on entry to LONG_HELD and at each repeat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign key_level     = key_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues expected pulse events with their cycle stamps,
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_key_event_decoder;

  localparam int LONG_CNT   = 10;
  localparam int REPEAT_CNT = 4;
  localparam int CNT_W      = 4;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_RPT   = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;
  logic key_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, busy;

  key_event_decoder #(
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic [4:0] p, input logic b);
    exp_t e;
    e.cyc = c;
    e.pulses = p;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    logic [6:0] act;
    act = {key_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, busy};
    checks++;
    if (act === 7'b0) passed++;
    else $display("FAIL %s: outputs=%b required=0000000", name, act);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got=%b required=%b", name, act, req);
  endtask

  // Monitor: every cycle with a pulse must match the oldest queued event exactly.
  always @(negedge clk) begin
    logic [4:0] act;
    exp_t e;
    if (mon_en) begin
      act = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
      if (act !== 5'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: cycle=%0d pulses=%b busy=%b required=no event", cyc, act, busy);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && act === e.pulses && busy === e.busy) passed++;
          else $display("FAIL event: cycle=%0d pulses=%b busy=%b required cycle=%0d pulses=%b busy=%b",
                        cyc, act, busy, e.cyc, e.pulses, e.busy);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    key_in = 1'b0;
    step(3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(20);
    check_idle("reset_idle");

    // single-cycle glitch
    key_in = 1'b1;
    expect_ev(cyc + 1, EV_PRESS, 1'b1);
    step(1);
    key_in = 1'b0;
    expect_ev(cyc + 1, EV_REL | EV_SHORT, 1'b0);
    step(4);

    // short press of 5 cycles
    key_in = 1'b1;
    expect_ev(cyc + 1, EV_PRESS, 1'b1);
    step(2);
    check_bit("short_key_level", key_level, 1'b1);
    check_bit("short_busy", busy, 1'b1);
    step(3);
    key_in = 1'b0;
    expect_ev(cyc + 1, EV_REL | EV_SHORT, 1'b0);
    step(4);
    check_idle("after_short");

    // 20-cycle hold: long at +10, repeats at +14/+18 when built
    c = cyc;
    key_in = 1'b1;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    expect_ev(c + 11, EV_LONG, 1'b1);
`ifdef KEY_AUTO_REPEAT_EN
    expect_ev(c + 15, EV_RPT, 1'b1);
    expect_ev(c + 19, EV_RPT, 1'b1);
`endif
    step(20);
    key_in = 1'b0;
    expect_ev(cyc + 1, EV_REL, 1'b0);
    step(4);

    // fall exactly on the long threshold cycle: release wins
    c = cyc;
    key_in = 1'b1;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    step(10);
    key_in = 1'b0;
    expect_ev(c + 11, EV_REL | EV_SHORT, 1'b0);
    step(4);

    // one cycle before the threshold
    c = cyc;
    key_in = 1'b1;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    step(9);
    key_in = 1'b0;
    expect_ev(c + 10, EV_REL | EV_SHORT, 1'b0);
    step(4);

    // one cycle after the threshold: long then plain release
    c = cyc;
    key_in = 1'b1;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    expect_ev(c + 11, EV_LONG, 1'b1);
    step(11);
    key_in = 1'b0;
    expect_ev(c + 12, EV_REL, 1'b0);
    step(4);

    // reset pulse during LONG_HELD with key held
    c = cyc;
    key_in = 1'b1;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    expect_ev(c + 11, EV_LONG, 1'b1);
    step(12);
    check_bit("long_held_busy", busy, 1'b1);
    rst_n = 1'b0;
    step(1);
    check_idle("reset_in_long_held");
    rst_n = 1'b1;
    c = cyc;
    expect_ev(c + 1, EV_PRESS, 1'b1);
    expect_ev(c + 11, EV_LONG, 1'b1);
    step(12);
    key_in = 1'b0;
    expect_ev(c + 13, EV_REL, 1'b0);
    step(4);
    check_idle("final_idle");

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL missing_events: outstanding=%0d required=0 (next cycle=%0d pulses=%b)",
                  exp_q.size(), exp_q[0].cyc, exp_q[0].pulses);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
